// File: rtl/keccak_squeeze.sv
// keccak_squeeze: streams the rate portion of a Keccak state as 64-bit lanes,
// requesting extra permutations when the digest is longer than the rate.
module keccak_squeeze #(
    parameter int unsigned OUT_WORDS  = 4,
    parameter int unsigned RATE_LANES = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [1599:0] state_in,
    output logic          busy,
    output logic          perm_req,
    input  logic          perm_done,
    output logic [63:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last
);

    localparam int unsigned LANE_W  = 64;
    localparam int unsigned STATE_W = 1600;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned CNT_W   = 8;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(OUT_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(RATE_LANES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT  = 2'd1,
        PERM = 2'd2
    } state_t;

    state_t             state;
    logic [STATE_W-1:0] s_reg;
    logic [IDX_W-1:0]   lane_idx;
    logic [CNT_W-1:0]   word_cnt;

    // Lane i is A[y][x] with i = 5*y + x, so lane i sits at bits [64*i +: 64], z=0 at LSB.
    function automatic logic [LANE_W-1:0] lane_of(input logic [STATE_W-1:0] s,
                                                   input logic [IDX_W-1:0]   idx);
        logic [10:0] base;
        base = {idx, 6'd0};
        return s[base +: LANE_W];
    endfunction

    // Squeeze FSM: captures states, walks the rate lanes and drives all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            perm_req   <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            lane_idx   <= '0;
            word_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state      <= OUT;
                        s_reg      <= state_in;
                        lane_idx   <= '0;
                        word_cnt   <= '0;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                        dout       <= lane_of(state_in, '0);
                        dout_valid <= 1'b1;
                        dout_last  <= (LAST_WORD == CNT_W'(0));
                    end
                end

                OUT: begin
                    if (dout_ready) begin
                        if (word_cnt == LAST_WORD) begin
                            // Final word wins over a rate boundary: no extra permutation.
                            state      <= IDLE;
                            load_ready <= 1'b1;
                            busy       <= 1'b0;
                            dout       <= '0;
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                        end else if (lane_idx == LAST_LANE) begin
                            state      <= PERM;
                            word_cnt   <= word_cnt + CNT_W'(1);
                            perm_req   <= 1'b1;
                            dout       <= '0;
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                        end else begin
                            lane_idx   <= lane_idx + IDX_W'(1);
                            word_cnt   <= word_cnt + CNT_W'(1);
                            dout       <= lane_of(s_reg, lane_idx + IDX_W'(1));
                            dout_last  <= ((word_cnt + CNT_W'(1)) == LAST_WORD);
                        end
                    end
                end

                PERM: begin
                    if (perm_done) begin
                        state      <= OUT;
                        s_reg      <= state_in;
                        lane_idx   <= '0;
                        perm_req   <= 1'b0;
                        dout       <= lane_of(state_in, '0);
                        dout_valid <= 1'b1;
                        dout_last  <= (word_cnt == LAST_WORD);
                    end
                end

                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b1;
                    busy       <= 1'b0;
                    perm_req   <= 1'b0;
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
